// File: rtl/arb_requester_if.sv
// arb_requester_if
//   Bundles the command, local-data, arbiter and shared-bus signals of one
//   requester agent.
//   master : the requester agent (drives cmd_ready, din_ready, req, bus_*, timeout)
//   slave  : the surrounding logic (local command/data source, arbiter, bus sink)
//   Signals:
//     cmd_valid/cmd_len/cmd_ready  burst command handshake (burst = cmd_len+1 beats)
//     din_valid/din_data/din_ready local data beat handshake
//     req/grant                    this master's request/grant bits at the arbiter
//     bus_valid/bus_data/bus_last  registered beat on the shared bus
//     timeout                      one-cycle pulse when a grant wait expires
interface arb_requester_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ready;
    logic              din_valid;
    logic [DATA_W-1:0] din_data;
    logic              din_ready;
    logic              req;
    logic              grant;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              timeout;

    modport master (
        input  cmd_valid, cmd_len, din_valid, din_data, grant,
        output cmd_ready, din_ready, req, bus_valid, bus_data, bus_last, timeout
    );

    modport slave (
        output cmd_valid, cmd_len, din_valid, din_data, grant,
        input  cmd_ready, din_ready, req, bus_valid, bus_data, bus_last, timeout
    );
endinterface

// File: rtl/arb_requester.sv
// arb_requester
//   Requester-side agent for a two-way round-robin arbiter. Accepts a burst
//   command, requests the bus, streams cmd_len+1 beats while granted, then
//   drops req for one cycle so the arbiter can rotate. A grant wait longer
//   than TIMEOUT cycles forces a one-cycle backoff with a timeout pulse.
//   Ports:
//     clk  single clock, rising edge
//     rst  asynchronous reset, active low
//     ifc  arb_requester_if.master (command, local data, req/grant, bus, timeout)
module arb_requester #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    arb_requester_if.master  ifc
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;

    logic [2:0]        state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              wait_expire;
    logic              cmd_ready_c;
    logic              din_ready_c;
    logic              cmd_hs;
    logic              beat_hs;
    logic              last_beat;

    logic              bus_valid_p1;
    logic              bus_last_p1;
    logic [DATA_W-1:0] bus_data_p1;
    logic              timeout_p1;

    // Saturating increment: the wait counter must never wrap back to zero.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + WAIT_W'(1);
    endfunction

    assign cmd_ready_c = (state == S_IDLE);
    assign din_ready_c = (state == S_XFER) && ifc.grant;
    assign cmd_hs      = ifc.cmd_valid && cmd_ready_c;
    assign beat_hs     = ifc.din_valid && din_ready_c;
    assign last_beat   = (beat_cnt == '0);
    assign wait_nxt    = sat_inc(wait_cnt);
    assign wait_expire = (TIMEOUT != 0) && (wait_nxt == TO_VAL);

    // req comes only from the state register, so it is glitch-free to the arbiter.
    assign ifc.req       = (state == S_REQ) || (state == S_XFER);
    assign ifc.cmd_ready = cmd_ready_c;
    assign ifc.din_ready = din_ready_c;
    assign ifc.bus_valid = bus_valid_p1;
    assign ifc.bus_last  = bus_last_p1;
    assign ifc.bus_data  = bus_data_p1;
    assign ifc.timeout   = timeout_p1;

    // Stage p0 -> p1: control FSM and registered bus beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
            bus_valid_p1 <= 1'b0;
            bus_last_p1  <= 1'b0;
            bus_data_p1  <= '0;
            timeout_p1   <= 1'b0;
        end else begin
            bus_valid_p1 <= beat_hs;
            bus_last_p1  <= beat_hs && last_beat;
            timeout_p1   <= 1'b0;
            if (beat_hs)
                bus_data_p1 <= ifc.din_data;

            case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        beat_cnt <= ifc.cmd_len;
                        wait_cnt <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant in the same cycle the wait expires takes priority.
                    if (ifc.grant) begin
                        state <= S_XFER;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_expire) begin
                            state      <= S_BACKOFF;
                            timeout_p1 <= 1'b1;
                        end
                    end
                end
                S_BACKOFF: begin
                    wait_cnt <= '0;
                    state    <= S_REQ;
                end
                S_XFER: begin
                    // Losing grant simply blocks din_ready; the burst resumes in place.
                    if (beat_hs) begin
                        if (last_beat)
                            state <= S_RELEASE;
                        else
                            beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Requester-side agent for the two-way round-robin arbiter: one instance sits in front of each bus master and drives that master's `req` bit into the arbiter while consuming the matching `grant` bit. The agent accepts a burst command from local logic, requests the shared bus, and streams the burst's data beats onto the bus while granted. It then releases `req` for at least one cycle so the arbiter can rotate. A grant-wait timeout with backoff keeps a starved master from holding `req` indefinitely.

## Interface
- `DATA_W`, 8, width of data beats.
- `LEN_W`, 4, width of the burst-length field; a burst is `cmd_len+1` beats, so 1 to 2^LEN_W beats.
- `TIMEOUT`, 15, number of cycles in REQ without grant before backoff. A value of 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `cmd_valid`  in  1  burst command valid.
- `cmd_len`  in  LEN_W  beats minus one.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are 1.
- `din_valid`  in  1  local data beat valid.
- `din_data`  in  DATA_W  local data beat.
- `din_ready`  out  1  beat consumed when both `din_valid` and `din_ready` are 1.
- `req`  out  1  bus request to the arbiter (this master's bit).
- `grant`  in  1  grant from the arbiter (this master's bit).
- `bus_valid`  out  1  registered beat valid on the shared bus.
- `bus_data`  out  DATA_W  registered beat data.
- `bus_last`  out  1  marks the final beat of a burst; qualified by `bus_valid`.
- `timeout`  out  1  one-cycle pulse when a grant wait expires.

## Operation
- States: IDLE, REQ, XFER, RELEASE, BACKOFF. The state register is the only source of `req`: `req` = 1 in REQ and XFER, and 0 in all other states.
- IDLE: `cmd_ready` = 1. On a command handshake, latch `cmd_len` into the beat counter and go to REQ. `cmd_ready` is 0 in every other state, so commands offered while busy are not accepted.
- REQ:
  - If `grant` = 1, go to XFER.
  - Otherwise the wait counter increments. When it reaches TIMEOUT (TIMEOUT ≠ 0), go to BACKOFF and pulse `timeout`.
  - The wait counter clears on entry to REQ.
- BACKOFF: one cycle with `req` = 0, then back to REQ.
- XFER:
  - `din_ready` = `grant`, combinational. `din_ready` is 0 in every state other than XFER.
  - Each beat handshake decrements the beat counter.
  - The handshake on the beat where the counter equals 0 is the last beat; after it, go to RELEASE.
  - If `grant` drops mid-burst (preemption or arbiter reset), stall: keep `req` = 1, accept no beats, lose no data, and resume when `grant` returns. No timeout applies in XFER.
- RELEASE: one cycle with `req` = 0, then IDLE. This guarantees a low gap between consecutive bursts.
- Bus output: on every beat handshake, `bus_valid` = 1, `bus_data` = `din_data`, and `bus_last` = (counter == 0), all on the next cycle. In all other cycles `bus_valid` = 0 and `bus_last` = 0; `bus_data` holds its last value.
- Widths: the beat counter is LEN_W bits. The wait counter is clog2(TIMEOUT+1) bits and saturates; it does not wrap.
- Reset (any cycle, including mid-XFER): state goes to IDLE and the burst is abandoned; no `bus_last` is emitted for it. Output values during reset:
  - `req` = 0, `bus_valid` = 0, `bus_last` = 0, `bus_data` = 0, `timeout` = 0.
  - `cmd_ready` = 1 and `din_ready` = 0 (decoded from IDLE).
  - Both counters = 0.

## Timing
- Command handshake at cycle 0 → `req` high at cycle 1.
- `grant` sampled high at the edge ending cycle k → XFER in cycle k+1. The first `din_ready` can be 1 in cycle k+1.
- Beat handshake at cycle n → `bus_valid` and `bus_data` at cycle n+1. Latency is 1 cycle.
- Last beat handshake at cycle m:
  - `req` low at m+1, with `bus_valid` = 1 and `bus_last` = 1 at m+1.
  - IDLE at m+2, with `cmd_ready` = 1 at m+2.
- Minimum command-to-command spacing: len+4 cycles (grant immediate, `din_valid` always high).
- Timeout: `req` is high for exactly TIMEOUT cycles, then low for 1 cycle. `timeout` is high in the first BACKOFF cycle.
- A `grant` that arrives in the same cycle the wait counter reaches TIMEOUT wins: go to XFER, no `timeout` pulse.

## Test plan
- Reset held low with random inputs → `req` = 0, `bus_valid` = 0, `cmd_ready` = 1, `din_ready` = 0, `timeout` = 0. Release reset → outputs unchanged until a command arrives.
- `cmd_len` = 0, `grant` tied high, `din_data` = 0xA5 → `req` high for 2 cycles; one bus beat 0xA5 with `bus_last` = 1; `cmd_ready` back at cycle 4.
- `cmd_len` = 3, beats 0x11/0x22/0x33/0x44 with `din_valid` gaps, and a second `cmd_valid` held during the burst → 4 bus beats in order, `bus_last` only on 0x44, `cmd_ready` = 0 throughout, second command accepted only after RELEASE.
- `grant` dropped for 3 cycles after beat 2 of a 4-beat burst → `din_ready` = 0 and `bus_valid` = 0 for those 3 cycles, `req` stays 1, remaining beats are delivered intact.
- TIMEOUT = 4, `grant` held 0 → `req` pattern 1,1,1,1,0 repeating with a `timeout` pulse on each 0 cycle. Then assert `grant` on the 4th REQ cycle → XFER, no pulse.
- Reset asserted mid-XFER after beat 1 of 4, then released → IDLE immediately, `req` = 0, no `bus_last`. A new command then completes normally.
